snn_frame_ctrl: RTL and testbench

Parametrised frame controller between the UART byte interfaces, the 1-bit input-image RAM and the SNN classifier core. It collects N_PIXELS received bytes, thresholds each to one bit and writes it to RAM at sequential addresses. It then pulses the core start, waits for the core result and transmits the ASCII result (optionally followed by CR LF). It adds a receive timeout, overrun detection and a result latch for the LEDs.

---
 rtl/snn_frame_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_snn_frame_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_frame_ctrl.sv
// snn_frame_ctrl: frame controller between the UART byte interfaces, the
// 1-bit input-image RAM and the SNN classifier core.
//   - Collects N_PIXELS received bytes, thresholds each one to a single bit
//     and writes it to RAM at sequential addresses.
//   - Pulses core_start, waits for core_done, latches the ASCII result on led.
//   - Transmits the ASCII digit, optionally followed by CR LF.
//   - Aborts a stalled load after RX_TIMEOUT idle clocks (sticky err_timeout).
//   - Flags bytes that arrive while no frame is being accepted (sticky err_ovr).
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   rx_rdy, rx_data                   received byte strobe and data
//   ram_we, ram_addr, ram_wdata       image RAM write port / shared address
//   core_addr                         core read address (drives ram_addr outside LOAD)
//   core_start, core_done, core_digit classifier handshake and result
//   tx_start, tx_data, tx_rdy         transmitter request, byte, idle flag
//   led                               ASCII of the last result
//   busy, err_timeout, err_ovr        status
module snn_frame_ctrl #(
  parameter int unsigned N_PIXELS   = 784,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DIGIT_W    = 4,
  parameter logic [7:0]  PIX_THRESH = 8'h80,
  parameter int unsigned RX_TIMEOUT = 5000000,
  parameter bit          SEND_EOL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_rdy,
  input  logic [7:0]         rx_data,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_wdata,
  input  logic [ADDR_W-1:0]  core_addr,
  output logic               core_start,
  input  logic               core_done,
  input  logic [DIGIT_W-1:0] core_digit,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_rdy,
  output logic [7:0]         led,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_ovr
);

  localparam int unsigned TMO_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_CORE, TX_DIG, TX_WAIT, TX_CR, TX_LF
  } state_e;

  // Which byte the current TX_WAIT belongs to, so it knows where to go next.
  typedef enum logic [1:0] {SEL_DIG, SEL_CR, SEL_LF} tx_sel_e;

  state_e              state_q, state_d;
  tx_sel_e             tx_sel_q, tx_sel_d;
  logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                guard_q, guard_d;
  logic                core_start_q, core_start_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [7:0]          led_q, led_d;
  logic                busy_q, busy_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_ovr_q, err_ovr_d;
  logic                accept;
  logic                tmo_hit;

  function automatic logic [7:0] to_ascii(input logic [DIGIT_W-1:0] d);
    if (32'(d) < 32'd10) return 8'h30 + 8'(d);
    else                 return 8'h3F;
  endfunction

  // A byte is written the same cycle it arrives; gating with rst_n keeps the
  // write enable low while reset is held even if rx_rdy is active.
  assign accept    = rst_n && rx_rdy && ((state_q == IDLE) || (state_q == LOAD));
  assign ram_we    = accept;
  assign ram_wdata = (rx_data >= PIX_THRESH);
  assign ram_addr  = (state_q == LOAD) ? pix_cnt_q :
                     (accept ? '0 : core_addr);

  assign tmo_hit = (RX_TIMEOUT != 0) && ((32'(tmo_cnt_q) + 32'd1) == RX_TIMEOUT);

  always_comb begin
    state_d       = state_q;
    tx_sel_d      = tx_sel_q;
    pix_cnt_d     = pix_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    guard_d       = guard_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    led_d         = led_q;
    err_timeout_d = err_timeout_q;
    err_ovr_d     = err_ovr_q;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (rx_rdy) begin
          if (N_PIXELS == 1) begin
            pix_cnt_d = '0;
            state_d   = START;
          end else begin
            pix_cnt_d = ADDR_W'(1);
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        // A byte arriving on the terminal count still wins over the abort.
        if (rx_rdy) begin
          tmo_cnt_d = '0;
          if (pix_cnt_q == LAST_ADDR) begin
            pix_cnt_d = '0;
            state_d   = START;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end else if (tmo_hit) begin
          err_timeout_d = 1'b1;
          pix_cnt_d     = '0;
          tmo_cnt_d     = '0;
          state_d       = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      START: state_d = WAIT_CORE;
      WAIT_CORE: begin
        if (core_done) begin
          led_d   = to_ascii(core_digit);
          state_d = TX_DIG;
        end
      end
      TX_DIG, TX_CR, TX_LF: begin
        if (tx_rdy) begin
          tx_start_d = 1'b1;
          guard_d    = 1'b1;
          state_d    = TX_WAIT;
          if (state_q == TX_DIG) begin
            tx_data_d = led_q;
            tx_sel_d  = SEL_DIG;
          end else if (state_q == TX_CR) begin
            tx_data_d = 8'h0D;
            tx_sel_d  = SEL_CR;
          end else begin
            tx_data_d = 8'h0A;
            tx_sel_d  = SEL_LF;
          end
        end
      end
      TX_WAIT: begin
        // The transmitter drops tx_rdy only a cycle after seeing tx_start, so
        // the first cycle here must not be taken as "idle again".
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (tx_rdy) begin
          case (tx_sel_q)
            SEL_DIG: state_d = SEND_EOL ? TX_CR : IDLE;
            SEL_CR:  state_d = TX_LF;
            default: state_d = IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_rdy && (state_q != IDLE) && (state_q != LOAD)) err_ovr_d = 1'b1;

    // START always lasts exactly one cycle, so registering its entry yields
    // a single-cycle pulse aligned with the START state.
    core_start_d = (state_d == START);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tx_sel_q      <= SEL_DIG;
      pix_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      guard_q       <= 1'b0;
      core_start_q  <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      led_q         <= 8'h00;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_sel_q      <= tx_sel_d;
      pix_cnt_q     <= pix_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      guard_q       <= guard_d;
      core_start_q  <= core_start_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      led_q         <= led_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      err_ovr_q     <= err_ovr_d;
    end
  end

  assign core_start  = core_start_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign led         = led_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_ovr     = err_ovr_q;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Testbench for snn_frame_ctrl. Two instances share the receive, core and
// reset stimulus: dut_a sends CR LF after the digit, dut_b sends the digit
// only. Each has its own transmitter model. Expected RAM writes and transmit
// bytes are queued as stimulus is driven and compared against what the
// monitors captured from the DUT outputs.
module tb_snn_frame_ctrl;

  localparam int AW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic [AW-1:0] core_addr;
  logic          core_done;
  logic [DW-1:0] core_digit;
  logic          tx_hold;

  logic          ram_we_a, ram_wdata_a, core_start_a, tx_start_a, busy_a;
  logic          err_timeout_a, err_ovr_a, tx_rdy_a;
  logic [AW-1:0] ram_addr_a;
  logic [7:0]    tx_data_a, led_a;
  logic          ram_we_b, ram_wdata_b, core_start_b, tx_start_b, busy_b;
  logic          err_timeout_b, err_ovr_b, tx_rdy_b;
  logic [AW-1:0] ram_addr_b;
  logic [7:0]    tx_data_b, led_b;

  always #5 clk = ~clk;

  snn_frame_ctrl #(.N_PIXELS(8), .ADDR_W(AW), .DIGIT_W(DW), .PIX_THRESH(8'h80),
                   .RX_TIMEOUT(20), .SEND_EOL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
    .core_addr(core_addr), .core_start(core_start_a), .core_done(core_done),
    .core_digit(core_digit), .tx_start(tx_start_a), .tx_data(tx_data_a),
    .tx_rdy(tx_rdy_a), .led(led_a), .busy(busy_a),
    .err_timeout(err_timeout_a), .err_ovr(err_ovr_a));

  snn_frame_ctrl #(.N_PIXELS(8), .ADDR_W(AW), .DIGIT_W(DW), .PIX_THRESH(8'h80),
                   .RX_TIMEOUT(20), .SEND_EOL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .core_addr(core_addr), .core_start(core_start_b), .core_done(core_done),
    .core_digit(core_digit), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .tx_rdy(tx_rdy_b), .led(led_b), .busy(busy_b),
    .err_timeout(err_timeout_b), .err_ovr(err_ovr_b));

  // Transmitter models: busy for 6 cycles after each accepted tx_start.
  logic [3:0] txc_a, txc_b;
  assign tx_rdy_a = (txc_a == 4'd0) && !tx_hold;
  assign tx_rdy_b = (txc_b == 4'd0) && !tx_hold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txc_a <= 4'd0;
      txc_b <= 4'd0;
    end else begin
      if (tx_start_a) txc_a <= 4'd6; else if (txc_a != 4'd0) txc_a <= txc_a - 4'd1;
      if (tx_start_b) txc_b <= 4'd6; else if (txc_b != 4'd0) txc_b <= txc_b - 4'd1;
    end
  end

  // RAM model for dut_a.
  logic mem_a [16];
  always @(posedge clk) if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;

  // Monitors: capture DUT output events away from the active edge.
  logic [4:0] obs_wr   [256];
  logic [8:0] obs_tx_a [256];
  logic [8:0] obs_tx_b [256];
  int obs_wr_n = 0, obs_tx_a_n = 0, obs_tx_b_n = 0, cs_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we_a)     begin obs_wr[obs_wr_n & 255] <= {ram_addr_a, ram_wdata_a}; obs_wr_n <= obs_wr_n + 1; end
      if (tx_start_a)   begin obs_tx_a[obs_tx_a_n & 255] <= {tx_rdy_a, tx_data_a}; obs_tx_a_n <= obs_tx_a_n + 1; end
      if (tx_start_b)   begin obs_tx_b[obs_tx_b_n & 255] <= {tx_rdy_b, tx_data_b}; obs_tx_b_n <= obs_tx_b_n + 1; end
      if (core_start_a) cs_cnt <= cs_cnt + 1;
    end
  end

  logic [4:0] exp_wr[$];
  logic [8:0] exp_tx_a[$];
  logic [8:0] exp_tx_b[$];
  int rd_wr = 0, rd_tx_a = 0, rd_tx_b = 0;
  int n_pass = 0, n_total = 0;

  logic [7:0] frame1 [8] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h81, 8'h10, 8'hF0, 8'h80};
  logic [7:0] frame2 [8] = '{8'h7F, 8'h80, 8'h01, 8'hFE, 8'hC3, 8'h3C, 8'h80, 8'h7F};
  logic [7:0] frame3 [8] = '{8'h11, 8'h22, 8'h99, 8'hAA, 8'h80, 8'h00, 8'hFF, 8'h81};
  logic [7:0] frame4 [8] = '{8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'hFF};
  logic [7:0] frame5 [8] = '{8'h01, 8'h02, 8'h83, 8'h84, 8'hF5, 8'h06, 8'hF7, 8'h88};

  task automatic test_reset();
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; core_done = 1'b0;
    core_digit = '0; core_addr = 4'hA; tx_hold = 1'b0;
    #1;
    n_total++;
    if ({ram_we_a, core_start_a, tx_start_a, busy_a, err_timeout_a, err_ovr_a} !== 6'b0 ||
        tx_data_a !== 8'h00 || led_a !== 8'h00)
      $display("FAIL reset_hold: we/cs/ts/busy/et/eo=%b tx_data=%h led=%h want all 0",
               {ram_we_a, core_start_a, tx_start_a, busy_a, err_timeout_a, err_ovr_a}, tx_data_a, led_a);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || led_a !== 8'h00 || ram_addr_a !== core_addr || ram_we_a !== 1'b0)
      $display("FAIL reset_idle: busy=%b/%b led=%h ram_addr=%h ram_we=%b want 0/0 00 %h 0",
               busy_a, busy_b, led_a, ram_addr_a, ram_we_a, core_addr);
    else n_pass++;
  endtask

  // Sends one frame (gap idle cycles between bytes), then checks the start
  // pulse, the WAIT_CORE address routing, every RAM write and RAM contents.
  task automatic test_load(input logic [7:0] px [8], input int gap, input string name);
    int cs0;
    logic [4:0] e;
    cs0 = cs_cnt;
    for (int i = 0; i < 8; i++) begin
      rx_data = px[i];
      rx_rdy  = 1'b1;
      exp_wr.push_back({4'(i), px[i] >= 8'h80});
      @(posedge clk); #1;
      rx_rdy = 1'b0;
      if (i != 7) repeat (gap) begin @(posedge clk); #1; end
    end
    n_total++;
    if (core_start_a !== 1'b1 || busy_a !== 1'b1)
      $display("FAIL %s start_pulse: core_start=%b busy=%b want 1 1", name, core_start_a, busy_a);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (core_start_a !== 1'b0 || busy_a !== 1'b1 || ram_we_a !== 1'b0 ||
        ram_addr_a !== core_addr || (cs_cnt - cs0) !== 1)
      $display("FAIL %s wait_core: core_start=%b busy=%b ram_we=%b ram_addr=%h pulses=%0d want 0 1 0 %h 1",
               name, core_start_a, busy_a, ram_we_a, ram_addr_a, cs_cnt - cs0, core_addr);
    else n_pass++;
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front();
      n_total++;
      if (rd_wr >= obs_wr_n) $display("FAIL %s ram_write: missing write, want addr=%h bit=%b", name, e[4:1], e[0]);
      else begin
        if (obs_wr[rd_wr & 255] !== e)
          $display("FAIL %s ram_write: got addr=%h bit=%b want addr=%h bit=%b",
                   name, obs_wr[rd_wr & 255][4:1], obs_wr[rd_wr & 255][0], e[4:1], e[0]);
        else n_pass++;
        rd_wr++;
      end
    end
    n_total++;
    if (obs_wr_n !== rd_wr) $display("FAIL %s extra_writes: got %0d extra want 0", name, obs_wr_n - rd_wr);
    else n_pass++;
    rd_wr = obs_wr_n;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (mem_a[i] !== (px[i] >= 8'h80))
        $display("FAIL %s ram_bit[%0d]: got %b want %b", name, i, mem_a[i], px[i] >= 8'h80);
      else n_pass++;
    end
  endtask

  // Core returns a digit while the transmitters are held busy; then the
  // transmitters are released and the transmitted bytes are scoreboarded.
  task automatic test_classify(input logic [DW-1:0] d, input logic [7:0] exp_led);
    int n0, k;
    logic [8:0] e;
    exp_tx_a.push_back({1'b1, exp_led});
    exp_tx_a.push_back({1'b1, 8'h0D});
    exp_tx_a.push_back({1'b1, 8'h0A});
    exp_tx_b.push_back({1'b1, exp_led});
    tx_hold = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    core_done = 1'b1; core_digit = d;
    @(posedge clk); #1;
    core_done = 1'b0;
    n_total++;
    if (led_a !== exp_led || led_b !== exp_led)
      $display("FAIL led_%0d: got %h/%h want %h", d, led_a, led_b, exp_led);
    else n_pass++;
    n0 = obs_tx_a_n;
    repeat (8) begin @(posedge clk); #1; end
    n_total++;
    if (obs_tx_a_n !== n0 || busy_a !== 1'b1)
      $display("FAIL tx_while_busy_%0d: sends=%0d busy=%b want 0 1", d, obs_tx_a_n - n0, busy_a);
    else n_pass++;
    tx_hold = 1'b0;
    k = 0;
    while ((busy_a || busy_b) && k < 400) begin @(posedge clk); #1; k++; end
    n_total++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0)
      $display("FAIL idle_after_tx_%0d: busy=%b/%b want 0/0", d, busy_a, busy_b);
    else n_pass++;
    while (exp_tx_a.size() != 0) begin
      e = exp_tx_a.pop_front();
      n_total++;
      if (rd_tx_a >= obs_tx_a_n) $display("FAIL tx_a_%0d: missing byte want %h", d, e[7:0]);
      else begin
        if (obs_tx_a[rd_tx_a & 255] !== e)
          $display("FAIL tx_a_%0d: got rdy=%b data=%h want rdy=1 data=%h",
                   d, obs_tx_a[rd_tx_a & 255][8], obs_tx_a[rd_tx_a & 255][7:0], e[7:0]);
        else n_pass++;
        rd_tx_a++;
      end
    end
    while (exp_tx_b.size() != 0) begin
      e = exp_tx_b.pop_front();
      n_total++;
      if (rd_tx_b >= obs_tx_b_n) $display("FAIL tx_b_%0d: missing byte want %h", d, e[7:0]);
      else begin
        if (obs_tx_b[rd_tx_b & 255] !== e)
          $display("FAIL tx_b_%0d: got rdy=%b data=%h want rdy=1 data=%h",
                   d, obs_tx_b[rd_tx_b & 255][8], obs_tx_b[rd_tx_b & 255][7:0], e[7:0]);
        else n_pass++;
        rd_tx_b++;
      end
    end
    n_total++;
    if (obs_tx_a_n !== rd_tx_a || obs_tx_b_n !== rd_tx_b)
      $display("FAIL tx_extra_%0d: got %0d/%0d extra want 0/0", d, obs_tx_a_n - rd_tx_a, obs_tx_b_n - rd_tx_b);
    else n_pass++;
    rd_tx_a = obs_tx_a_n;
    rd_tx_b = obs_tx_b_n;
  endtask

  task automatic test_timeout();
    logic [4:0] e;
    n_total++;
    if (err_timeout_a !== 1'b0) $display("FAIL tmo_pre: err_timeout=%b want 0", err_timeout_a);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'hC0; rx_rdy = 1'b1;
      exp_wr.push_back({4'(i), 1'b1});
      @(posedge clk); #1;
      rx_rdy = 1'b0;
    end
    repeat (19) begin @(posedge clk); #1; end
    n_total++;
    if (err_timeout_a !== 1'b0 || busy_a !== 1'b1)
      $display("FAIL tmo_edge19: err_timeout=%b busy=%b want 0 1", err_timeout_a, busy_a);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (err_timeout_a !== 1'b1 || busy_a !== 1'b0 || err_timeout_b !== 1'b1)
      $display("FAIL tmo_edge20: err_timeout=%b/%b busy=%b want 1/1 0", err_timeout_a, err_timeout_b, busy_a);
    else n_pass++;
    while (exp_wr.size() != 0) begin
      e = exp_wr.pop_front();
      n_total++;
      if (rd_wr >= obs_wr_n || obs_wr[rd_wr & 255] !== e)
        $display("FAIL tmo_write: got %h (count %0d) want %h", obs_wr[rd_wr & 255], obs_wr_n - rd_wr, e);
      else n_pass++;
      rd_wr++;
    end
    rd_wr = obs_wr_n;
    repeat (2) begin @(posedge clk); #1; end
    test_load(frame3, 0, "after_tmo");
    test_classify(4'd3, 8'h33);
  endtask

  task automatic test_overrun();
    n_total++;
    if (err_ovr_a !== 1'b0) $display("FAIL ovr_pre: err_ovr=%b want 0", err_ovr_a);
    else n_pass++;
    test_load(frame4, 1, "ovr");
    rx_data = 8'hFF; rx_rdy = 1'b1;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    n_total++;
    if (err_ovr_a !== 1'b1 || obs_wr_n !== rd_wr || busy_a !== 1'b1 || err_timeout_a !== 1'b1)
      $display("FAIL ovr_inject: err_ovr=%b writes=%0d busy=%b err_timeout=%b want 1 0 1 1",
               err_ovr_a, obs_wr_n - rd_wr, busy_a, err_timeout_a);
    else n_pass++;
    rd_wr = obs_wr_n;
    test_classify(4'd5, 8'h35);
  endtask

  task automatic test_back_to_back();
    test_load(frame5, 0, "b2b");
    test_classify(4'd9, 8'h39);
  endtask

  task automatic test_reset_mid();
    int k;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h90; rx_rdy = 1'b1;
      @(posedge clk); #1;
      rx_rdy = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({ram_we_a, core_start_a, tx_start_a, busy_a, err_timeout_a, err_ovr_a} !== 6'b0 || led_a !== 8'h00)
      $display("FAIL rst_load: we/cs/ts/busy/et/eo=%b led=%h want 0 00",
               {ram_we_a, core_start_a, tx_start_a, busy_a, err_timeout_a, err_ovr_a}, led_a);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_wr = obs_wr_n; rd_tx_a = obs_tx_a_n; rd_tx_b = obs_tx_b_n;
    exp_wr.delete(); exp_tx_a.delete(); exp_tx_b.delete();
    @(posedge clk); #1;
    test_load(frame2, 0, "after_rst_load");
    core_done = 1'b1; core_digit = 4'd6;
    @(posedge clk); #1;
    core_done = 1'b0;
    k = 0;
    while (obs_tx_a_n == rd_tx_a && k < 50) begin @(posedge clk); #1; k++; end
    n_total++;
    if (obs_tx_a_n == rd_tx_a || busy_a !== 1'b1 || tx_data_a !== 8'h36)
      $display("FAIL pre_rst_tx: sends=%0d busy=%b tx_data=%h want 1 1 36", obs_tx_a_n - rd_tx_a, busy_a, tx_data_a);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({ram_we_a, core_start_a, tx_start_a, busy_a} !== 4'b0 || tx_data_a !== 8'h00 || led_a !== 8'h00)
      $display("FAIL rst_txwait: we/cs/ts/busy=%b tx_data=%h led=%h want 0 00 00",
               {ram_we_a, core_start_a, tx_start_a, busy_a}, tx_data_a, led_a);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_wr = obs_wr_n; rd_tx_a = obs_tx_a_n; rd_tx_b = obs_tx_b_n;
    @(posedge clk); #1;
    test_load(frame1, 1, "after_rst_tx");
    test_classify(4'd1, 8'h31);
  endtask

  initial begin
    test_reset();
    test_load(frame1, 2, "frame1");
    test_classify(4'd7, 8'h37);
    test_load(frame2, 1, "frame2");
    test_classify(4'd12, 8'h3F);
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
